bug_ctl: RTL and testbench

- Game-logic stage directly upstream of draw_bug.
- Produces bug sprite position (x_bugpos/y_bugpos) and visibility once per frame.
- Detects mouse clicks on the sprite and keeps a score.
- Sits in the pclk (40 MHz, 800x600) domain, fed by timing vsync and MouseCtl outputs.

---
 rtl/bug_pkg.sv | 69 ++++++
 rtl/lfsr16.sv | 24 ++
 rtl/bug_ctl.sv | 196 +++++++++++++++++++
 tb/tb_bug_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bug_pkg.sv
// Shared state encoding, default screen/sprite geometry and small arithmetic helpers for bug_ctl.
// Pure definitions: no latency of its own.
// No flow control: functions are combinational.
package bug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        HIT,
        RESPAWN
    } state_t;

    typedef struct packed {
        logic [11:0] pos;
        logic        dir;   // 1 = moving towards larger coordinates
    } axis_t;

    localparam int          DEF_SCREEN_W   = 800;
    localparam int          DEF_SCREEN_H   = 600;
    localparam int          DEF_BUG_W      = 64;
    localparam int          DEF_BUG_H      = 64;
    localparam int          DEF_STEP       = 2;
    localparam int          DEF_HIT_FRAMES = 30;
    localparam logic [15:0] DEF_LFSR_SEED  = 16'hACE1;

    localparam int X_MAX = DEF_SCREEN_W - DEF_BUG_W;
    localparam int Y_MAX = DEF_SCREEN_H - DEF_BUG_H;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // One frame of motion on one axis, bouncing off 0 and lim.
    function automatic axis_t axis_step(
        input logic [11:0] pos,
        input logic        dir,
        input logic [11:0] lim,
        input logic [11:0] step
    );
        axis_t r;
        r.pos = pos;
        r.dir = dir;
        if (dir) begin
            if (({1'b0, pos} + {1'b0, step}) >= {1'b0, lim}) begin
                r.pos = lim;
                r.dir = 1'b0;
            end else begin
                r.pos = pos + step;
            end
        end else if (pos <= step) begin
            r.pos = '0;
            r.dir = 1'b1;
        end else begin
            r.pos = pos - step;
        end
        return r;
    endfunction

    // lo <= p < lo + size, evaluated in 13 bits so the upper bound cannot wrap.
    function automatic logic in_span(
        input logic [11:0] p,
        input logic [11:0] lo,
        input logic [12:0] size
    );
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + size));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length LFSR used as the respawn randomness source.
// Latency: new value every clk; output is the register itself.
// No backpressure: always advances; a zero state reloads the seed.
module lfsr16
    import bug_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else if (lfsr == 16'h0000) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/bug_ctl.sv
// Bug sprite game logic: per-frame bouncing motion, mouse click hit test, saturating score.
// Latency: position updates 2 pclk after vsync_in is first sampled high; hit_pulse 3 pclk after mouse_left is first sampled high.
// No backpressure: inputs consumed every pclk, outputs held stable between frame ticks.
module bug_ctl
    import bug_pkg::*;
#(
    parameter int          SCREEN_W   = DEF_SCREEN_W,
    parameter int          SCREEN_H   = DEF_SCREEN_H,
    parameter int          BUG_W      = DEF_BUG_W,
    parameter int          BUG_H      = DEF_BUG_H,
    parameter int          STEP       = DEF_STEP,
    parameter int          HIT_FRAMES = DEF_HIT_FRAMES,
    parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    output logic [11:0] x_bugpos,
    output logic [11:0] y_bugpos,
    output logic        bug_visible,
    output logic [7:0]  score,
    output logic        hit_pulse
);

    localparam logic [11:0] X_LIM    = 12'(SCREEN_W - BUG_W);
    localparam logic [11:0] Y_LIM    = 12'(SCREEN_H - BUG_H);
    localparam logic [11:0] X_HOME   = 12'((SCREEN_W - BUG_W) / 2);
    localparam logic [11:0] Y_HOME   = 12'((SCREEN_H - BUG_H) / 2);
    localparam logic [11:0] STEP_V   = 12'(STEP);
    localparam logic [7:0]  LAST_CNT = 8'(HIT_FRAMES - 1);

    // Input conditioning
    logic        vs_q, vs_q2;
    logic        ml_s1, ml_s2, ml_s3;
    logic [11:0] xq1, xq2, yq1, yq2;
    logic [11:0] mx, my;
    logic        tick, click;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            ml_s1 <= 1'b0;
            ml_s2 <= 1'b0;
            ml_s3 <= 1'b0;
            xq1   <= '0;
            xq2   <= '0;
            yq1   <= '0;
            yq2   <= '0;
            mx    <= '0;
            my    <= '0;
        end else begin
            vs_q  <= vsync_in;
            vs_q2 <= vs_q;
            ml_s1 <= mouse_left;
            ml_s2 <= ml_s1;
            ml_s3 <= ml_s2;
            xq1   <= xpos;
            xq2   <= xq1;
            yq1   <= ypos;
            yq2   <= yq1;
            // Mouse coordinates arrive from another domain; only accept a pair seen twice in a row.
            if (xq1 == xq2 && yq1 == yq2) begin
                mx <= xq2;
                my <= yq2;
            end
        end
    end

    assign tick  = vs_q & ~vs_q2;
    assign click = ml_s2 & ~ml_s3;

    // Randomness for respawn
    logic [15:0] lfsr;
    logic        lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (pclk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lfsr_unused = ^lfsr[13:10];

    logic [11:0] rx, ry;

    always_comb begin
        rx = {2'b00, lfsr[9:0]};
        if (rx > X_LIM) begin
            rx = rx - 12'd512;
        end
        ry = {3'b000, lfsr[8:0]};
        if (ry > Y_LIM) begin
            ry = ry - 12'd256;
        end
    end

    // Motion and hit test
    axis_t xs, ys;
    logic  dx_q, dy_q;
    logic  in_box;

    assign xs     = axis_step(x_bugpos, dx_q, X_LIM, STEP_V);
    assign ys     = axis_step(y_bugpos, dy_q, Y_LIM, STEP_V);
    assign in_box = in_span(mx, x_bugpos, 13'(BUG_W)) && in_span(my, y_bugpos, 13'(BUG_H));

    // FSM
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] x_d, y_d;
    logic        dx_d, dy_d;
    logic [7:0]  score_d;
    logic        hit_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_bugpos;
        y_d     = y_bugpos;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        score_d = score;
        hit_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                // A hit takes priority over a coincident frame tick; the sprite stays put.
                if (click && in_box) begin
                    hit_d   = 1'b1;
                    score_d = (score == 8'hFF) ? score : score + 8'd1;
                    cnt_d   = '0;
                    state_d = HIT;
                end else if (tick) begin
                    x_d  = xs.pos;
                    dx_d = xs.dir;
                    y_d  = ys.pos;
                    dy_d = ys.dir;
                end
            end
            HIT: begin
                if (tick) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = RESPAWN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            RESPAWN: begin
                x_d     = rx;
                y_d     = ry;
                dx_d    = lfsr[14];
                dy_d    = lfsr[15];
                state_d = MOVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            x_bugpos  <= X_HOME;
            y_bugpos  <= Y_HOME;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            cnt_q     <= '0;
            score     <= '0;
            hit_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_bugpos  <= x_d;
            y_bugpos  <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            cnt_q     <= cnt_d;
            score     <= score_d;
            hit_pulse <= hit_d;
        end
    end

    // Blink with a period of 8 frames while frozen after a hit.
    assign bug_visible = (state_q == HIT) ? ~cnt_q[2] : 1'b1;

endmodule

// File: tb/tb_bug_ctl.sv
// Randomized self-checking bench for bug_ctl against a frame-level reference model.
module tb_bug_ctl;

    localparam int XLIM = 736;
    localparam int YLIM = 536;
    localparam int HF   = 30;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        vsync_in;
    logic [11:0] xpos, ypos;
    logic        mouse_left;
    logic [11:0] x_bugpos, y_bugpos;
    logic        bug_visible;
    logic [7:0]  score;
    logic        hit_pulse;

    bug_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .xpos        (xpos),
        .ypos        (ypos),
        .mouse_left  (mouse_left),
        .x_bugpos    (x_bugpos),
        .y_bugpos    (y_bugpos),
        .bug_visible (bug_visible),
        .score       (score),
        .hit_pulse   (hit_pulse)
    );

    always #5 pclk = ~pclk;

    // Clock edges since reset release: the LFSR state is the seed stepped this many times.
    int unsigned edges = 0;
    always @(posedge pclk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    int unsigned pulse_total = 0;
    always @(negedge pclk) begin
        if (hit_pulse === 1'b1) pulse_total <= pulse_total + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: 0 = waiting for first frame, 1 = moving, 2 = frozen after hit.
    int m_x, m_y, m_dx, m_dy, m_state, m_cnt, m_score;
    int sat_hits = 0;

    function automatic logic [15:0] lfsr_at(input int unsigned n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int unsigned i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    task automatic model_reset();
        m_x = 368; m_y = 268; m_dx = 1; m_dy = 1;
        m_state = 0; m_cnt = 0; m_score = 0;
    endtask

    task automatic move_axis(inout int p, inout int d, input int lim);
        if (d == 1) begin
            if (p + 2 >= lim) begin p = lim; d = 0; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; d = 1; end
            else p = p - 2;
        end
    endtask

    // k = edge count when vsync_in was driven high; respawn happens two edges later.
    task automatic model_tick(input int unsigned k);
        logic [15:0] l;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            move_axis(m_x, m_dx, XLIM);
            move_axis(m_y, m_dy, YLIM);
        end else if (m_cnt == HF - 1) begin
            l = lfsr_at(k + 2);
            m_x = int'(l[9:0]);
            if (m_x > XLIM) m_x -= 512;
            m_y = int'(l[8:0]);
            if (m_y > YLIM) m_y -= 256;
            m_dx = int'(l[14]);
            m_dy = int'(l[15]);
            m_state = 1;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic bit on_bug(input int cx, input int cy);
        return cx >= m_x && cx < m_x + 64 && cy >= m_y && cy < m_y + 64;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_x"}, 32'(x_bugpos), m_x);
        chk({tag, "_y"}, 32'(y_bugpos), m_y);
        chk({tag, "_vis"}, 32'(bug_visible), (m_state == 2) ? ((m_cnt & 4) == 0) : 1);
        chk({tag, "_score"}, 32'(score), m_score);
    endtask

    task automatic do_tick();
        int unsigned k;
        @(negedge pclk); vsync_in = 1'b1; k = edges;
        @(negedge pclk); vsync_in = 1'b0;
        repeat (2) @(negedge pclk);
        model_tick(k);
    endtask

    task automatic do_click(input int cx, input int cy, input bit with_tick);
        int unsigned k, p0;
        bit hit;
        @(negedge pclk); xpos = 12'(cx); ypos = 12'(cy);
        repeat (4) @(negedge pclk);
        p0 = pulse_total; mouse_left = 1'b1;
        @(negedge pclk); k = edges; if (with_tick) vsync_in = 1'b1;
        @(negedge pclk); vsync_in = 1'b0;
        @(negedge pclk); mouse_left = 1'b0;
        repeat (3) @(negedge pclk);
        hit = (m_state == 1) && on_bug(cx, cy);
        if (hit) begin
            if (m_score == 255) sat_hits++;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_cnt = 0;
            m_state = 2;
        end else if (with_tick) begin
            model_tick(k);
        end
        chk("hit_pulse_count", pulse_total - p0, 32'(hit));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int r, cx, cy;
        vsync_in = 1'b0; xpos = '0; ypos = '0; mouse_left = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge pclk);
        model_reset();
        check_all("reset");
        chk("reset_pulse", 32'(hit_pulse), 0);
        rst = 1'b1;

        // First tick only leaves IDLE, then free motion bouncing off all four walls.
        do_tick(); check_all("first_tick");
        do_tick(); do_tick(); check_all("tick3");
        for (int i = 0; i < 560; i++) begin
            do_tick(); check_all("bounce");
        end

        // Directed hit/miss around a sprite at (368,268).
        @(negedge pclk); rst = 1'b0;
        @(negedge pclk); rst = 1'b1;
        model_reset();
        do_tick(); check_all("b_start");
        do_click(367, 268, 0); check_all("miss_left");
        do_click(432, 300, 0); check_all("miss_right_excl");
        do_click(400, 267, 0); check_all("miss_top");
        do_click(400, 332, 0); check_all("miss_bottom_excl");
        do_click(400, 300, 0); check_all("hit");
        do_click(400, 300, 0); check_all("click_in_hit");
        for (int i = 0; i < HF; i++) begin
            do_tick(); check_all("hit_frames");
            if (i == 10) begin do_click(380, 280, 1); check_all("click_tick_in_hit"); end
        end
        chk("respawn_x_range", 32'(x_bugpos <= 12'd736), 1);
        chk("respawn_y_range", 32'(y_bugpos <= 12'd536), 1);

        // Random play until the score has saturated and a few more hits landed.
        for (int it = 0; it < 20000 && !(m_score == 255 && sat_hits >= 3); it++) begin
            r = int'($urandom_range(0, 15));
            if (m_state == 2) begin
                if (r < 14) do_tick();
                else do_click(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), r[0]);
            end else begin
                case (r % 8)
                    0, 1, 2: do_tick();
                    3, 4: do_click(m_x + int'($urandom_range(0, 63)), m_y + int'($urandom_range(0, 63)), 1'b0);
                    5: do_click(m_x + int'($urandom_range(0, 63)), m_y + int'($urandom_range(0, 63)), 1'b1);
                    6: begin
                        cx = m_x - 1 + int'($urandom_range(0, 65));
                        cy = m_y - 1 + int'($urandom_range(0, 65));
                        do_click((cx < 0) ? 0 : cx, (cy < 0) ? 0 : cy, r[3]);
                    end
                    default: do_click(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), r[3]);
                endcase
            end
            check_all("rand");
        end
        chk("score_saturated", 32'(score), 255);

        // Asynchronous reset while a hit pulse is in flight.
        for (int i = 0; i < 40 && m_state != 1; i++) do_tick();
        @(negedge pclk); xpos = 12'(m_x + 10); ypos = 12'(m_y + 10);
        repeat (4) @(negedge pclk);
        mouse_left = 1'b1;
        repeat (2) @(negedge pclk);
        @(posedge pclk);
        #1 chk("pulse_before_reset", 32'(hit_pulse), 32'(m_state == 1));
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset_pulse", 32'(hit_pulse), 0);
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        begin
            int unsigned p0;
            p0 = pulse_total;
            repeat (3) @(negedge pclk);
            mouse_left = 1'b0;
            repeat (4) @(negedge pclk);
            chk("no_pulse_after_release", pulse_total - p0, 0);
        end
        do_tick(); check_all("post_reset_tick");
        do_tick(); check_all("post_reset_move");

        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $finish;
    end

endmodule
